softmax_forward: RTL and testbench

Row-wise fixed-point softmax stage directly downstream of the dense forward layer in the training datapath. It takes the `N` logit rows of `CHAR_NUM` values produced by the dense stage and emits `N` probability rows of the same shape for the cross-entropy/backward stage. It uses the same level-held `run`/`valid` protocol as the dense stage. All `N` rows are processed in parallel lanes that share one controller and one element counter.

---
 rtl/softmax_forward.sv | 221 ++++++++++++++++++++++
 tb/tb_softmax_forward.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/softmax_forward.sv
// Row-wise fixed-point softmax: N parallel lanes share one FSM (max, exp2, reciprocal, normalise).
// Optional define SOFTMAX_ARGMAX_EN adds the per-row argmax output amax.
module softmax_forward #(
  parameter int N          = 2,
  parameter int CHAR_NUM   = 16,
  parameter int N_LEN      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LOG2E      = 369
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  input  logic [N*CHAR_NUM*N_LEN-1:0]    d,
  output logic                           valid,
  output logic [N*CHAR_NUM*N_LEN-1:0]    q
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [N*$clog2(CHAR_NUM)-1:0]  amax
`endif
);

  localparam int CIW  = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;
  localparam int MAXC = (CHAR_NUM > N_LEN) ? CHAR_NUM : N_LEN;
  localparam int CW   = $clog2(MAXC);
  localparam int EW   = FRAC_WIDTH + 1;
  localparam int SW   = FRAC_WIDTH + 1 + CIW;
  localparam int DW   = SW + N_LEN;
  localparam int PW   = N_LEN + FRAC_WIDTH + 3;

  localparam logic [EW-1:0] ONE      = EW'(1) << FRAC_WIDTH;
  localparam logic [DW-1:0] REM_INIT = DW'(1) << (2 * FRAC_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_MAX, S_EXP, S_RECIP, S_NORM, S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            valid_q, valid_d;
  logic [N*CHAR_NUM*N_LEN-1:0]     q_q, q_d;
  logic signed [N_LEN-1:0]         m_q   [N];
  logic signed [N_LEN-1:0]         m_d   [N];
  logic [SW-1:0]                   sum_q [N];
  logic [SW-1:0]                   sum_d [N];
  logic [DW-1:0]                   rem_q [N];
  logic [DW-1:0]                   rem_d [N];
  logic [EW-1:0]                   r_q   [N];
  logic [EW-1:0]                   r_d   [N];
  logic [EW-1:0]                   e_q   [N][CHAR_NUM];
  logic [EW-1:0]                   e_d   [N][CHAR_NUM];
`ifdef SOFTMAX_ARGMAX_EN
  localparam int AW = $clog2(CHAR_NUM);
  logic [N*AW-1:0]                 amax_q, amax_d;
`endif

  logic [CIW-1:0] ci;
  logic           last_c, last_n;

  assign ci     = cnt_q[CIW-1:0];
  assign last_c = (cnt_q == CW'(CHAR_NUM - 1));
  assign last_n = (cnt_q == CW'(N_LEN - 1));

  always_comb begin
    logic signed [N_LEN-1:0] x;
    logic signed [N_LEN:0]   s;
    logic signed [PW-1:0]    s_ext, lg, prod, t, k;
    logic [EW-1:0]           ev, qv;
    logic [DW-1:0]           trial;
    logic [CW-1:0]           shamt;
    logic [2*EW-1:0]         pq;
    logic                    qbit;
    int unsigned             base;
    x     = '0;
    s     = '0;
    s_ext = '0;
    lg    = PW'(LOG2E);
    prod  = '0;
    t     = '0;
    k     = '0;
    ev    = '0;
    qv    = '0;
    trial = '0;
    shamt = '0;
    pq    = '0;
    qbit  = 1'b0;
    base  = 0;
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    q_d     = q_q;
    m_d     = m_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    r_d     = r_q;
    e_d     = e_q;
`ifdef SOFTMAX_ARGMAX_EN
    amax_d  = amax_q;
`endif
    if (!run) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      q_d     = '0;
`ifdef SOFTMAX_ARGMAX_EN
      amax_d  = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_MAX;
          cnt_d   = '0;
          valid_d = 1'b0;
          q_d     = '0;
          m_d     = '{default: '0};
          sum_d   = '{default: '0};
          r_d     = '{default: '0};
          rem_d   = '{default: REM_INIT};
          e_d     = '{default: '0};
`ifdef SOFTMAX_ARGMAX_EN
          amax_d  = '0;
`endif
        end
        S_MAX: begin
          for (int unsigned i = 0; i < N; i++) begin
            base = (i * CHAR_NUM + 32'(ci)) * N_LEN;
            x    = d[base +: N_LEN];
            // strict compare keeps the lowest index on ties
            if (cnt_q == '0 || x > m_q[i]) begin
              m_d[i] = x;
`ifdef SOFTMAX_ARGMAX_EN
              amax_d[i*AW +: AW] = AW'(ci);
`endif
            end
          end
          cnt_d   = last_c ? '0 : cnt_q + CW'(1);
          state_d = last_c ? S_EXP : S_MAX;
        end
        S_EXP: begin
          for (int unsigned i = 0; i < N; i++) begin
            base  = (i * CHAR_NUM + 32'(ci)) * N_LEN;
            x     = d[base +: N_LEN];
            s     = (N_LEN+1)'(x) - (N_LEN+1)'(m_q[i]);
            s_ext = PW'(s);
            prod  = s_ext * lg;
            t     = prod >>> FRAC_WIDTH;
            // k = -floor(t) in real terms; the low FRAC_WIDTH bits of t are f
            k     = -(t >>> FRAC_WIDTH);
            if (k > PW'(FRAC_WIDTH)) ev = '0;
            else                     ev = {1'b1, t[FRAC_WIDTH-1:0]} >> k;
            e_d[i][ci] = ev;
            sum_d[i]   = sum_q[i] + SW'(ev);
          end
          cnt_d   = last_c ? '0 : cnt_q + CW'(1);
          state_d = last_c ? S_RECIP : S_EXP;
        end
        S_RECIP: begin
          shamt = CW'(N_LEN - 1) - cnt_q;
          for (int unsigned i = 0; i < N; i++) begin
            trial = DW'(sum_q[i]) << shamt;
            qbit  = (rem_q[i] >= trial);
            if (qbit) rem_d[i] = rem_q[i] - trial;
            r_d[i] = {r_q[i][EW-2:0], qbit};
          end
          cnt_d   = last_n ? '0 : cnt_q + CW'(1);
          state_d = last_n ? S_NORM : S_RECIP;
        end
        S_NORM: begin
          for (int unsigned i = 0; i < N; i++) begin
            base = (i * CHAR_NUM + 32'(ci)) * N_LEN;
            pq   = ((2*EW)'(e_q[i][ci]) * (2*EW)'(r_q[i])) >> FRAC_WIDTH;
            qv   = (pq > (2*EW)'(ONE)) ? ONE : pq[EW-1:0];
            q_d[base +: N_LEN] = N_LEN'(qv);
          end
          cnt_d   = last_c ? '0 : cnt_q + CW'(1);
          state_d = last_c ? S_DONE : S_NORM;
        end
        S_DONE: begin
          valid_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      q_q     <= '0;
      m_q     <= '{default: '0};
      sum_q   <= '{default: '0};
      rem_q   <= '{default: '0};
      r_q     <= '{default: '0};
      e_q     <= '{default: '0};
`ifdef SOFTMAX_ARGMAX_EN
      amax_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      m_q     <= m_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      e_q     <= e_d;
`ifdef SOFTMAX_ARGMAX_EN
      amax_q  <= amax_d;
`endif
    end
  end

  assign valid = valid_q;
  assign q     = q_q;
`ifdef SOFTMAX_ARGMAX_EN
  assign amax  = amax_q;
`endif

endmodule

// File: tb/tb_softmax_forward.sv
// Directed bench for softmax_forward: hand-computed probabilities, latency, abort and reset cases.
module tb_softmax_forward;
  localparam int N   = 2;
  localparam int C   = 16;
  localparam int L   = 16;
  localparam int F   = 8;
  localparam int LAT = 3*C + L + 1;
  localparam int AW  = $clog2(C);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic [N*C*L-1:0] d = '0;
  logic [N*C*L-1:0] q;
  logic             valid;
`ifdef SOFTMAX_ARGMAX_EN
  logic [N*AW-1:0]  amax;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          exp_q    [N][C];
  int          exp_amax [N];

  softmax_forward #(.N(N), .CHAR_NUM(C), .N_LEN(L), .FRAC_WIDTH(F), .LOG2E(369)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .d     (d),
    .valid (valid),
`ifdef SOFTMAX_ARGMAX_EN
    .amax  (amax),
`endif
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic fill(input int lane, input int logit, input int qv, input int am);
    for (int j = 0; j < C; j++) begin
      d[(lane*C + j)*L +: L] = L'(logit);
      exp_q[lane][j] = qv;
    end
    exp_amax[lane] = am;
  endtask

  task automatic set_el(input int lane, input int j, input int logit, input int qv);
    d[(lane*C + j)*L +: L] = L'(logit);
    exp_q[lane][j] = qv;
  endtask

  task automatic check_outputs(input string name);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < C; j++)
        check($sformatf("%s q[%0d][%0d]", name, i, j), 32'(q[(i*C + j)*L +: L]), exp_q[i][j]);
`ifdef SOFTMAX_ARGMAX_EN
      check($sformatf("%s amax[%0d]", name, i), 32'(amax[i*AW +: AW]), exp_amax[i]);
`endif
    end
  endtask

  task automatic run_and_wait(input string name);
    int lat;
    lat = -1;
    @(negedge clk) run = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
    check({name, " latency"}, lat, LAT);
    check_outputs(name);
    repeat (3) @(posedge clk);
    #1;
    check({name, " valid held"}, 32'(valid), 1);
    check_outputs({name, " held"});
  endtask

  task automatic drop_run(input string name);
    @(negedge clk) run = 1'b0;
    @(posedge clk); #1;
    check({name, " valid cleared"}, 32'(valid), 0);
    check({name, " q cleared"}, 32'(|q), 0);
  endtask

  task automatic load_t23;
    // lane 0: single 4.0 at index 5 -> e=4 elsewhere, sum=316, r=207
    fill(0, 0, 3, 5);
    set_el(0, 5, 1024, 207);
    // lane 1: tied 2.0 at 3 and 9 -> e=35 elsewhere, sum=1002, r=65
    fill(1, 0, 8, 3);
    set_el(1, 3, 512, 65);
    set_el(1, 9, 512, 65);
  endtask

  initial begin
    #2;
    check("reset valid", 32'(valid), 0);
    check("reset q", 32'(|q), 0);
`ifdef SOFTMAX_ARGMAX_EN
    check("reset amax", 32'(amax), 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // uniform rows: e=256, sum=4096, r=16, q=16
    fill(0, 0, 16, 0);
    fill(1, -5, 16, 0);
    run_and_wait("uniform");
    drop_run("uniform");

    load_t23();
    run_and_wait("peak_tie");
    check("tie q3==q9", 32'(q[(C + 3)*L +: L]), 32'(q[(C + 9)*L +: L]));
    drop_run("peak_tie");

    // abort while the divider is iterating
    @(negedge clk) run = 1'b1;
    repeat (40) @(posedge clk);
    drop_run("abort_recip");
    run_and_wait("after_abort");
    drop_run("after_abort");

    // asynchronous reset while NORM has written part of q
    @(negedge clk) run = 1'b1;
    repeat (58) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("rst_norm valid", 32'(valid), 0);
    check("rst_norm q", 32'(|q), 0);
    run = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // wide spread: small elements underflow to e=0, the max gets exactly 1.0
    fill(0, 0, 0, 10);
    set_el(0, 10, 1600, 256);
    set_el(0, 2, -100, 0);
    fill(1, -32768, 0, 15);
    set_el(1, 15, 32767, 256);
    run_and_wait("spread");
    drop_run("spread");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
